// File: rtl/vga_if.sv
// VGA timing/pixel bundle shared by the stream selector and its sources.
// 'in' is the consumer view, 'out' the producer view.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, rgb, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, rgb, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_stream_select.sv
// Frame-synchronous selector for N_CH VGA streams. Select requests are held
// pending and only take effect on the rising edge of vblnk of the active
// stream, so the output never switches source mid-frame.
// Optional feature: define VGA_STREAM_SELECT_BLINK_EN to let blink_en
// alternate the output between active_sel and channel 0 every BLINK_FRAMES
// frames.
module vga_stream_select #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned SEL_W       = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                in [N_CH],
  vga_if.out               out,
  input  logic             sel_req,
  input  logic [SEL_W-1:0] sel,
  input  logic             blink_en,
  output logic [SEL_W-1:0] active_sel,
  output logic             sel_ack,
  output logic             sel_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  // Flattened copies of the input streams so they can be muxed by index.
  logic [N_CH-1:0][10:0] hc_arr, vc_arr;
  logic [N_CH-1:0][11:0] rgb_arr;
  logic [N_CH-1:0]       hs_arr, vs_arr, hb_arr, vb_arr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign hc_arr[g]  = in[g].hcount;
    assign vc_arr[g]  = in[g].vcount;
    assign rgb_arr[g] = in[g].rgb;
    assign hs_arr[g]  = in[g].hsync;
    assign vs_arr[g]  = in[g].vsync;
    assign hb_arr[g]  = in[g].hblnk;
    assign vb_arr[g]  = in[g].vblnk;
  end

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] pending_q, pending_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             prev_vb_q;
  logic             vb_act, boundary, req_ok, req_valid;
  logic [SEL_W-1:0] src;

  assign vb_act    = vb_arr[active_q];
  assign boundary  = vb_act && !prev_vb_q;
  assign req_ok    = 32'(sel) < N_CH;
  assign req_valid = sel_req && req_ok;

  // Next-state for the select FSM; a boundary in Pend applies the value
  // pending before any request arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    ack_d     = 1'b0;
    err_d     = sel_req && !req_ok;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          pending_d = sel;
          state_d   = StPend;
        end
      end
      StPend: begin
        if (boundary) begin
          active_d = pending_q;
          ack_d    = 1'b1;
          if (!req_valid) state_d = StIdle;
        end
        if (req_valid) pending_d = sel;
      end
      default: state_d = StIdle;
    endcase
  end

  // Select FSM and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      active_q  <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      prev_vb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      prev_vb_q <= vb_act;
    end
  end

`ifdef VGA_STREAM_SELECT_BLINK_EN
  logic [7:0] frame_cnt_q;
  logic       phase_q;

  // Blink frame counter; restarts whenever a new selection lands.
  always_ff @(posedge clk) begin
    if (rst || !blink_en || ack_d) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        phase_q     <= !phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign src = (blink_en && (active_q != '0) && phase_q) ? '0 : active_q;
`else
  logic unused_blink;
  assign unused_blink = blink_en ^ BLINK_FRAMES[0];
  assign src          = active_q;
`endif

  // Output register: all fields come from one source in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.rgb    <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
    end else begin
      out.hcount <= hc_arr[src];
      out.vcount <= vc_arr[src];
      out.rgb    <= rgb_arr[src];
      out.hsync  <= hs_arr[src];
      out.vsync  <= vs_arr[src];
      out.hblnk  <= hb_arr[src];
      out.vblnk  <= vb_arr[src];
    end
  end

  assign active_sel = active_q;
  assign sel_ack    = ack_q;
  assign sel_err    = err_q;

endmodule
